prog_loader: RTL

Streams a program image into instruction memory before the core runs: it accepts bytes over a valid/ready interface, assembles them into 9-bit machine-code words, and writes them to sequential instruction addresses. It holds the core in reset while loading and releases it when the terminating word arrives. It sits between the host/testbench byte source and the write port of the instruction memory that the PC fetch path reads.

---
 rtl/prog_loader_pkg.sv | 18 +
 rtl/prog_loader_if.sv | 22 ++
 rtl/prog_loader.sv | 107 ++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
// Word framing: low byte, then high byte carrying bit 8 and the last flag.
package prog_loader_pkg;
  localparam int D = 10;
  localparam int W = 9;
  localparam int LAST_BIT = 7;
  localparam int HI_DATA_BIT = 0;
  localparam logic [7:0] HI_RSVD = 8'h7E;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_WRITE,
    S_DONE,
    S_ERR
  } loader_state_t;
endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in and instruction-memory write port out.
// master = host/memory side, slave = loader side.
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic         wr_en;
  logic [D-1:0] wr_addr;
  logic [W-1:0] wr_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/prog_loader.sv
// Assembles byte pairs into 9-bit words and writes them to sequential
// instruction addresses, holding the core in reset until the image ends.
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  prog_loader_if.slave bus,
  output logic         core_reset,
  output logic         loaded,
  output logic         err,
  output logic [D:0]   word_count
);

  loader_state_t state, state_nxt;
  logic [D-1:0]  addr;
  logic [7:0]    lo;
  logic          hi_bit;
  logic          last;
  logic          hs;
  logic          rsvd_bad;
  logic          addr_max;

  assign hs       = bus.in_valid && bus.in_ready;
  assign rsvd_bad = (bus.in_data & HI_RSVD) != 8'h00;
  assign addr_max = addr == {D{1'b1}};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR:
        if (start) state_nxt = S_LO;
      S_LO:
        if (hs) state_nxt = S_HI;
      S_HI:
        if (hs) state_nxt = rsvd_bad ? S_ERR : S_WRITE;
      S_WRITE:
        if (last)          state_nxt = S_DONE;
        else if (addr_max) state_nxt = S_ERR;
        else               state_nxt = S_LO;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  // Word assembly, address and count; a bad high byte is never stored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr       <= '0;
      lo         <= '0;
      hi_bit     <= 1'b0;
      last       <= 1'b0;
      word_count <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_ERR:
          if (start) begin
            addr       <= '0;
            word_count <= '0;
          end
        S_LO:
          if (hs) lo <= bus.in_data;
        S_HI:
          if (hs && !rsvd_bad) begin
            hi_bit <= bus.in_data[HI_DATA_BIT];
            last   <= bus.in_data[LAST_BIT];
          end
        S_WRITE: begin
          word_count <= word_count + 1'b1;
          if (!last && !addr_max) addr <= addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    bus.in_ready = 1'b0;
    bus.wr_en    = 1'b0;
    core_reset   = 1'b1;
    loaded       = 1'b0;
    err          = 1'b0;
    unique case (state)
      S_LO, S_HI: bus.in_ready = 1'b1;
      S_WRITE:    bus.wr_en    = 1'b1;
      S_DONE: begin
        core_reset = 1'b0;
        loaded     = 1'b1;
      end
      S_ERR:      err = 1'b1;
      default: ;
    endcase
  end

  assign bus.wr_addr = addr;
  assign bus.wr_data = {hi_bit, lo};

endmodule
